// File: rtl/xm_mem_access_if.sv
// rtl/xm_mem_access_if.sv - data-memory/MMIO request/acknowledge bus driven by the M stage
interface xm_mem_access_if #(
    parameter int ADDR_W = 12
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/xm_mem_access.sv
// rtl/xm_mem_access.sv - M stage: lw/sw access with X/M stall, M/W result register (option: ACCESS_TIMEOUT_EN)
module xm_mem_access #(
    parameter int          ADDR_W   = 12,
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ERR_CODE = 32'd7
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic                  i_xm_valid,
    input  logic [31:0]           i_xm_insn,
    input  logic [31:0]           i_xm_pc,
    input  logic [31:0]           i_xm_o,
    input  logic [31:0]           i_xm_b,
    input  logic [31:0]           i_xm_rstat,
    output logic                  o_xm_stall,
    xm_mem_access_if.master       mem,
    output logic                  o_mw_valid,
    output logic [31:0]           o_mw_insn,
    output logic [31:0]           o_mw_pc,
    output logic [31:0]           o_mw_o,
    output logic [31:0]           o_mw_d,
    output logic [31:0]           o_mw_rstat
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    localparam logic [4:0] OPC_SW = 5'b00111;
    localparam logic [4:0] OPC_LW = 5'b01000;

    logic [0:0]        r_state;
    logic              r_we;
    logic              r_is_lw;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_mw_valid;
    logic [31:0]       r_mw_insn;
    logic [31:0]       r_mw_pc;
    logic [31:0]       r_mw_o;
    logic [31:0]       r_mw_d;
    logic [31:0]       r_mw_rstat;

    logic w_is_sw;
    logic w_is_lw;
    logic w_mem_op;
    logic w_done;
    logic w_timeout;

    assign w_is_sw  = (i_xm_insn[31:27] == OPC_SW);
    assign w_is_lw  = (i_xm_insn[31:27] == OPC_LW);
    assign w_mem_op = i_xm_valid & (w_is_sw | w_is_lw);

    // mem_req is high exactly while in WAIT, so ack is only ever looked at there
    assign w_done   = (r_state == S_WAIT) & mem.mem_ack;

`ifdef ACCESS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [CNT_W-1:0] r_wait_cnt;

    // an ack arriving in the expiry cycle completes normally, hence the ~ack term
    assign w_timeout = (r_state == S_WAIT) & ~mem.mem_ack & (r_wait_cnt == CNT_W'(TIMEOUT));

    // count WAIT cycles; zero whenever idle so each access starts fresh
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == S_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end
`else
    logic w_unused_cfg;

    assign w_timeout    = 1'b0;
    assign w_unused_cfg = ^{ERR_CODE, TIMEOUT};
`endif

    // hold X/M from decode of a mem op until the cycle the access finishes
    assign o_xm_stall = (r_state == S_IDLE) ? w_mem_op : ~(w_done | w_timeout);

    // two-state access sequencer plus the M/W result register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_is_lw    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mw_valid <= 1'b0;
            r_mw_insn  <= '0;
            r_mw_pc    <= '0;
            r_mw_o     <= '0;
            r_mw_d     <= '0;
            r_mw_rstat <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mem_op) begin
                        r_state    <= S_WAIT;
                        r_we       <= w_is_sw;
                        r_is_lw    <= w_is_lw;
                        r_addr     <= i_xm_o[ADDR_W-1:0];
                        r_wdata    <= i_xm_b;
                        r_mw_valid <= 1'b0;
                    end else begin
                        r_mw_valid <= i_xm_valid;
                        r_mw_insn  <= i_xm_insn;
                        r_mw_pc    <= i_xm_pc;
                        r_mw_o     <= i_xm_o;
                        r_mw_d     <= '0;
                        r_mw_rstat <= i_xm_rstat;
                    end
                end
                default: begin
                    if (w_done || w_timeout) begin
                        r_state    <= S_IDLE;
                        r_mw_valid <= 1'b1;
                        r_mw_insn  <= i_xm_insn;
                        r_mw_pc    <= i_xm_pc;
                        r_mw_o     <= i_xm_o;
                        r_mw_d     <= (w_done && r_is_lw) ? mem.mem_rdata : 32'd0;
                        r_mw_rstat <= w_done ? i_xm_rstat : ERR_CODE;
                    end
                end
            endcase
        end
    end

    assign mem.mem_req   = (r_state == S_WAIT);
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_wdata = r_wdata;

    assign o_mw_valid = r_mw_valid;
    assign o_mw_insn  = r_mw_insn;
    assign o_mw_pc    = r_mw_pc;
    assign o_mw_o     = r_mw_o;
    assign o_mw_d     = r_mw_d;
    assign o_mw_rstat = r_mw_rstat;
endmodule

// File: tb/tb_xm_mem_access.sv
// tb/tb_xm_mem_access.sv - directed bench for xm_mem_access with an op-level reference model
module tb_xm_mem_access;
    localparam int          ADDR_W = 12;
    localparam int          TMO    = 4;
    localparam logic [31:0] ERR    = 32'd7;
    localparam logic [31:0] I_ADD  = 32'h0000_0000;
    localparam logic [31:0] I_SW   = 32'h3800_0000;
    localparam logic [31:0] I_LW   = 32'h4000_0000;

    logic clk = 1'b0;
    logic clr_n = 1'b0;
    always #5 clk = ~clk;

    logic        cur_valid = 1'b0;
    logic [31:0] cur_insn = '0, cur_pc = '0, cur_o = '0, cur_b = '0, cur_rstat = '0;
    int          cur_delay = 0;
    logic [31:0] cur_rdata = '0;
    logic        stray_ack = 1'b0;

    logic        xm_stall;
    logic        mw_valid;
    logic [31:0] mw_insn, mw_pc, mw_o, mw_d, mw_rstat;

    xm_mem_access_if #(.ADDR_W(ADDR_W)) mem_if ();

    xm_mem_access #(.ADDR_W(ADDR_W), .TIMEOUT(TMO), .ERR_CODE(ERR)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .i_xm_valid (cur_valid),
        .i_xm_insn  (cur_insn),
        .i_xm_pc    (cur_pc),
        .i_xm_o     (cur_o),
        .i_xm_b     (cur_b),
        .i_xm_rstat (cur_rstat),
        .o_xm_stall (xm_stall),
        .mem        (mem_if),
        .o_mw_valid (mw_valid),
        .o_mw_insn  (mw_insn),
        .o_mw_pc    (mw_pc),
        .o_mw_o     (mw_o),
        .o_mw_d     (mw_d),
        .o_mw_rstat (mw_rstat)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: one op at a time, counted in cycles since presented
    logic        model_en = 1'b0;
    logic        adv_flag = 1'b0;
    int          age = 0;
    logic        exp_valid = 1'b0;
    logic [31:0] exp_insn, exp_pc, exp_o, exp_d, exp_rstat;

    function automatic logic op_is_lw();
        return cur_valid && (cur_insn[31:27] == 5'b01000);
    endfunction

    function automatic logic op_is_sw();
        return cur_valid && (cur_insn[31:27] == 5'b00111);
    endfunction

    function automatic logic op_times_out();
`ifdef ACCESS_TIMEOUT_EN
        return (op_is_lw() || op_is_sw()) && (cur_delay < 0 || cur_delay > TMO);
`else
        return 1'b0;
`endif
    endfunction

    // cycle index (from presentation) in which X/M is allowed to advance
    function automatic int advance_age();
        if (!(op_is_lw() || op_is_sw())) return 0;
        if (op_times_out()) return TMO + 1;
        if (cur_delay < 0) return 1 << 30;
        return cur_delay + 1;
    endfunction

    always @(negedge clk) begin
        if (model_en) begin
            int  aa;
            logic mem_op;
            aa     = advance_age();
            mem_op = op_is_lw() || op_is_sw();
            check("mw_valid", {31'd0, mw_valid}, {31'd0, exp_valid});
            if (exp_valid) begin
                check("mw_insn", mw_insn, exp_insn);
                check("mw_pc", mw_pc, exp_pc);
                check("mw_o", mw_o, exp_o);
                check("mw_d", mw_d, exp_d);
                check("mw_rstat", mw_rstat, exp_rstat);
            end
            check("xm_stall", {31'd0, xm_stall}, {31'd0, (age < aa)});
            check("mem_req", {31'd0, mem_if.mem_req}, {31'd0, (mem_op && age >= 1)});
            if (mem_op && age >= 1) begin
                check("mem_we", {31'd0, mem_if.mem_we}, {31'd0, op_is_sw()});
                check("mem_addr", {20'd0, mem_if.mem_addr}, {20'd0, cur_o[ADDR_W-1:0]});
                check("mem_wdata", mem_if.mem_wdata, cur_b);
            end
            if (age == aa) begin
                exp_valid = cur_valid;
                exp_insn  = cur_insn;
                exp_pc    = cur_pc;
                exp_o     = cur_o;
                exp_d     = (op_is_lw() && !op_times_out()) ? cur_rdata : 32'd0;
                exp_rstat = op_times_out() ? ERR : cur_rstat;
                age       = 0;
                adv_flag  = 1'b1;
            end else begin
                exp_valid = 1'b0;
                age++;
            end
        end
    end

    // ---------------- memory responder: acks after cur_delay WAIT cycles (never if negative)
    int wcnt = 0;
    initial begin
        mem_if.mem_ack   = 1'b0;
        mem_if.mem_rdata = '0;
    end
    always @(posedge clk) begin
        #1;
        if (mem_if.mem_req) begin
            mem_if.mem_ack   = (cur_delay >= 0) && (wcnt == cur_delay);
            mem_if.mem_rdata = mem_if.mem_ack ? cur_rdata : 32'hBAD0_BAD0;
            wcnt++;
        end else begin
            wcnt = 0;
            mem_if.mem_ack   = stray_ack;
            mem_if.mem_rdata = 32'h5A5A_5A5A;
        end
    end

    // ---------------- driver
    int          last_stall;
    logic        last_first_req;
    logic        seen_we;
    logic [31:0] seen_addr, seen_wdata;

    // call at posedge+1; returns at posedge+1 right after the op's result was registered
    task automatic issue(input logic v, input logic [31:0] insn, input logic [31:0] pc,
                         input logic [31:0] o, input logic [31:0] b, input logic [31:0] rs,
                         input int delay, input logic [31:0] rdata);
        int n;
        cur_valid = v; cur_insn = insn; cur_pc = pc; cur_o = o; cur_b = b; cur_rstat = rs;
        cur_delay = delay; cur_rdata = rdata;
        adv_flag = 1'b0;
        last_stall = 0;
        n = 0;
        forever begin
            @(negedge clk);
            if (n == 0) last_first_req = mem_if.mem_req;
            if (xm_stall) last_stall++;
            if (mem_if.mem_req) begin
                seen_we = mem_if.mem_we; seen_addr = {20'd0, mem_if.mem_addr};
                seen_wdata = mem_if.mem_wdata;
            end
            @(posedge clk);
            n++;
            if (adv_flag) break;
            if (n > 500) begin
                check("advance_timeout", 32'(n), 32'd0);
                break;
            end
        end
        #1;
        adv_flag = 1'b0;
        cur_valid = 1'b0; cur_insn = '0; cur_delay = 0;
    endtask

    initial begin
        #1;
        check("rst_mw_valid", {31'd0, mw_valid}, 32'd0);
        check("rst_mem_req", {31'd0, mem_if.mem_req}, 32'd0);
        check("rst_mw_pc", mw_pc, 32'd0);
        check("rst_mw_rstat", mw_rstat, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk); clr_n = 1'b1;
        @(posedge clk); #1; model_en = 1'b1;
        @(posedge clk); #1;

        // 1: add passes through in one cycle
        issue(1'b1, I_ADD | 32'h21, 32'h10, 32'h5, 32'h0, 32'h0, 0, 32'h0);
        check("t1_stall_cycles", 32'(last_stall), 32'd0);
        check("t1_mw_valid", {31'd0, mw_valid}, 32'd1);
        check("t1_mw_o", mw_o, 32'h5);
        check("t1_mw_d", mw_d, 32'h0);

        // 2: lw, ack after three WAIT cycles; upper address bits dropped
        issue(1'b1, I_LW | 32'h7, 32'h14, 32'hFFFF_F024, 32'h0, 32'h3, 3, 32'hDEADBEEF);
        check("t2_stall_cycles", 32'(last_stall), 32'd4);
        check("t2_mem_addr", seen_addr, 32'h024);
        check("t2_mem_we", {31'd0, seen_we}, 32'd0);
        check("t2_mw_d", mw_d, 32'hDEADBEEF);
        check("t2_mw_rstat", mw_rstat, 32'h3);

        // 3: sw with immediate ack: 2-cycle latency
        issue(1'b1, I_SW, 32'h18, 32'h8, 32'h1234, 32'h0, 0, 32'h0);
        check("t3_stall_cycles", 32'(last_stall), 32'd1);
        check("t3_mem_we", {31'd0, seen_we}, 32'd1);
        check("t3_mem_wdata", seen_wdata, 32'h1234);
        check("t3_mw_d", mw_d, 32'h0);

        // 4: sw then lw back to back; req must drop for one cycle between
        issue(1'b1, I_SW, 32'h30, 32'h40, 32'hCAFE, 32'h0, 0, 32'h0);
        check("t4_first_pc", mw_pc, 32'h30);
        issue(1'b1, I_LW, 32'h34, 32'h44, 32'h0, 32'h0, 0, 32'h1111_2222);
        check("t4_gap_req", {31'd0, last_first_req}, 32'd0);
        check("t4_second_pc", mw_pc, 32'h34);
        check("t4_second_d", mw_d, 32'h1111_2222);

        // stray acks while idle, and an invalid slot carrying a lw opcode
        stray_ack = 1'b1;
        issue(1'b1, I_ADD, 32'h40, 32'h9, 32'h0, 32'h0, 0, 32'h0);
        issue(1'b0, I_LW, 32'h44, 32'hA, 32'h0, 32'h0, 0, 32'h0);
        check("inv_stall_cycles", 32'(last_stall), 32'd0);
        check("inv_mw_valid", {31'd0, mw_valid}, 32'd0);
        stray_ack = 1'b0;

        // mixed sequence checked by the model alone
        for (int i = 0; i < 12; i++) begin
            logic [31:0] ins;
            ins = (i % 3 == 0) ? I_LW : (i % 3 == 1) ? I_SW : (I_ADD | 32'(i));
            issue(1'b1, ins, 32'h100 + 32'(4 * i), $urandom, $urandom, $urandom,
                  int'($urandom_range(0, 3)), $urandom);
        end

`ifdef ACCESS_TIMEOUT_EN
        // 6: ack in the expiry cycle wins, then no ack at all aborts
        issue(1'b1, I_LW, 32'h200, 32'h50, 32'h0, 32'h9, TMO, 32'h7777_0000);
        check("t6_ack_wins_d", mw_d, 32'h7777_0000);
        check("t6_ack_wins_rstat", mw_rstat, 32'h9);
        issue(1'b1, I_LW, 32'h204, 32'h54, 32'h0, 32'h9, -1, 32'h0);
        check("t6_stall_cycles", 32'(last_stall), 32'd5);
        check("t6_mw_valid", {31'd0, mw_valid}, 32'd1);
        check("t6_mw_rstat", mw_rstat, 32'd7);
        check("t6_mw_d", mw_d, 32'd0);
`endif

        // 5: reset while waiting on a load
        cur_valid = 1'b1; cur_insn = I_LW; cur_pc = 32'h300; cur_o = 32'h60;
        cur_delay = -1; adv_flag = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("t5_req_before", {31'd0, mem_if.mem_req}, 32'd1);
        #2;
        model_en = 1'b0;
        clr_n = 1'b0;
        #1;
        check("t5_req_async", {31'd0, mem_if.mem_req}, 32'd0);
        check("t5_mw_valid", {31'd0, mw_valid}, 32'd0);
        cur_valid = 1'b0; cur_insn = '0; cur_delay = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        age = 0; exp_valid = 1'b0; adv_flag = 1'b0;
        @(posedge clk); #1;
        model_en = 1'b1;
        issue(1'b1, I_ADD, 32'h310, 32'h77, 32'h0, 32'h0, 0, 32'h0);
        check("t5_after_stall", 32'(last_stall), 32'd0);
        check("t5_after_o", mw_o, 32'h77);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
